// File: rtl/led_ex_ctrl.sv
// Push-key LED mode controller: OFF -> ON -> BLINK -> OFF on each key press.
// Define LED_EX_KEY_SYNC_EN to route KEY through a 2-flop synchronizer first.
module led_ex_ctrl #(
    parameter int unsigned BLINK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       KEY,
    output logic       LED,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BAD   = 2'd3
    } mode_e;

    localparam logic [7:0] CNT_LAST = 8'(BLINK_DIV - 1);

    mode_e      state_q;
    logic       led_q;
    logic [7:0] blinkCnt_q;
    logic       key_q;
    logic       keySampled;
    logic       press;

`ifdef LED_EX_KEY_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    assign keySampled = sync2_q;
`else
    assign keySampled = KEY;
`endif

    // key_q resets low, so a key already held at reset release counts as a press
    assign press = keySampled & ~key_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= MODE_OFF;
            led_q      <= 1'b0;
            blinkCnt_q <= 8'd0;
            key_q      <= 1'b0;
        end else begin
            key_q <= keySampled;
            case (state_q)
                MODE_OFF: begin
                    blinkCnt_q <= 8'd0;
                    if (press) begin
                        state_q <= MODE_ON;
                        led_q   <= 1'b1;
                    end else begin
                        led_q   <= 1'b0;
                    end
                end
                MODE_ON: begin
                    blinkCnt_q <= 8'd0;
                    led_q      <= 1'b1;
                    if (press) begin
                        state_q <= MODE_BLINK;
                    end
                end
                MODE_BLINK: begin
                    if (press) begin
                        state_q    <= MODE_OFF;
                        led_q      <= 1'b0;
                        blinkCnt_q <= 8'd0;
                    end else if (blinkCnt_q == CNT_LAST) begin
                        led_q      <= ~led_q;
                        blinkCnt_q <= 8'd0;
                    end else begin
                        blinkCnt_q <= blinkCnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= MODE_OFF;
                    led_q      <= 1'b0;
                    blinkCnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign LED   = led_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_led_ex_ctrl.sv
// Self-checking bench for led_ex_ctrl: directed scenarios then random key activity
// compared against a mode/age reference model.
`timescale 1ns/100ps
module tb_led_ex_ctrl;

    localparam int DIV = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       KEY = 1'b0;
    logic       LED;
    logic [1:0] STATE;

    int checkCount = 0;
    int errorCount = 0;

    // reference model: mode number, cycles spent in BLINK, last sampled key
    int   mMode = 0;
    int   mAge = 0;
    logic mPrev = 1'b0;
    logic mHist1 = 1'b0;
    logic mHist2 = 1'b0;
    logic randKey = 1'b0;

    led_ex_ctrl #(.BLINK_DIV(DIV)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .KEY   (KEY),
        .LED   (LED),
        .STATE (STATE)
    );

    always #1 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int expLed();
        if (mMode == 1) return 1;
        if (mMode == 2) return (((mAge / DIV) % 2) == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic modelReset();
        mMode  = 0;
        mAge   = 0;
        mPrev  = 1'b0;
        mHist1 = 1'b0;
        mHist2 = 1'b0;
    endtask

    task automatic modelEdge(input logic k);
        logic e;
        logic p;
`ifdef LED_EX_KEY_SYNC_EN
        e      = mHist2;
        mHist2 = mHist1;
        mHist1 = k;
`else
        e = k;
`endif
        p     = e && !mPrev;
        mPrev = e;
        if (p) begin
            mMode = (mMode + 1) % 3;
            mAge  = 0;
        end else if (mMode == 2) begin
            mAge++;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".state"}, int'(STATE), mMode);
        checkOutput({tag, ".led"}, int'(LED), expLed());
    endtask

    // drive KEY at a falling edge, let the rising edge act, check on the next falling edge
    task automatic applyStimulus(input logic k, input string tag);
        KEY = k;
        @(posedge CLK);
        modelEdge(k);
        @(negedge CLK);
        checkModel(tag);
    endtask

    // pull RST_N low between edges and confirm outputs clear without a clock edge
    task automatic asyncReset(input string tag);
        #0.3 RST_N = 1'b0;
        #0.2;
        modelReset();
        checkModel({tag, ".async"});
        @(negedge CLK);
        checkModel({tag, ".held"});
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        KEY   = 1'b0;
        #0.5;
        checkModel("rst0");
        @(negedge CLK);
        checkModel("rst1");
        @(negedge CLK);
        checkModel("rst2");
        RST_N = 1'b1;

        for (int p = 0; p < 3; p++) begin
            applyStimulus(1'b1, "pulse");
            for (int i = 0; i < 5; i++) applyStimulus(1'b0, "pulseGap");
        end

        applyStimulus(1'b1, "toOn");
        applyStimulus(1'b0, "toOnGap");
        applyStimulus(1'b1, "toBlink");
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, "blinkHold");

        asyncReset("midBlink");
        applyStimulus(1'b1, "postRst");
        applyStimulus(1'b0, "postRstGap");

        applyStimulus(1'b1, "toBlink2");
        applyStimulus(1'b0, "toBlink2Gap");
        applyStimulus(1'b1, "toOff");
        applyStimulus(1'b0, "toOffGap");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, "keyHeld");
        applyStimulus(1'b0, "keyRelease");

        KEY = 1'b1;
        asyncReset("keyAtRelease");
        applyStimulus(1'b1, "keyAtReleasePress");
        applyStimulus(1'b0, "keyAtReleaseGap");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) randKey = ~randKey;
            if ($urandom_range(0, 99) == 0) begin
                KEY = randKey;
                asyncReset("randRst");
            end else begin
                applyStimulus(randKey, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/led_ex_ctrl.md
LED_EX_CTRL -- requirements
Module: led_ex

Interface
REQ-001 Parameter: BLINK_DIV, default 4, half-period of the LED blink in clock cycles (legal range 1..255).
REQ-002 Port: CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: RST_N  input  1  reset; asynchronous, active-low.
REQ-004 Port: KEY  input  1  push-key; a press is a 0->1 transition of the sampled KEY level.
REQ-005 Port: LED  output  1  LED drive; registered.
REQ-006 Port: STATE  output  2  current mode code; registered (OFF=0, ON=1, BLINK=2; 3 unused).

Function
REQ-007 The block SHALL keep one registered copy of the previous sampled key level, key_q, updated every cycle.
REQ-008 A press SHALL be detected in a cycle where the sampled key is 1 and key_q is 0, giving exactly one press per 0->1 transition however long KEY stays high.
REQ-009 On a press, STATE SHALL advance OFF->ON, ON->BLINK, BLINK->OFF at the same rising edge.
REQ-010 Code 3, if ever reached, SHALL go to OFF at the next edge.
REQ-011 With no press, STATE SHALL hold.
REQ-012 In OFF, LED SHALL be 0.
REQ-013 In ON, LED SHALL be 1.
REQ-014 On entering BLINK, LED SHALL be 1 and an internal 8-bit blink counter SHALL be 0.
REQ-015 In BLINK, the counter SHALL increment each cycle; when it equals BLINK_DIV-1, LED SHALL toggle and the counter SHALL wrap to 0, giving a period of 2*BLINK_DIV cycles.
REQ-016 The blink counter SHALL be held at 0 outside BLINK.
REQ-017 LED and STATE SHALL update on the same edge, so LED reflects the new mode in the first cycle of that mode.
REQ-018 A 1-cycle KEY pulse that straddles a rising edge SHALL be captured as a press.

Reset
REQ-019 While RST_N=0, STATE=0 (OFF), LED=0, blink counter=0, key_q=0 and all synchronizer flops=0, independent of CLK.
REQ-020 Reset asserted mid-BLINK SHALL clear LED and STATE immediately, asynchronously.
REQ-021 If KEY is already 1 when reset releases, it SHALL count as one press, because key_q resets to 0.

Configuration
REQ-022 The macro LED_EX_KEY_SYNC_EN controls key synchronization.
REQ-023 When LED_EX_KEY_SYNC_EN is defined, KEY SHALL pass through a 2-flop synchronizer before edge detection, so a state change occurs 2 cycles later than without it.
REQ-024 When LED_EX_KEY_SYNC_EN is undefined, KEY SHALL be sampled directly, and STATE SHALL change at the first rising edge that samples KEY=1.

Verification (macro undefined, BLINK_DIV=4, clock period 2 time units)
REQ-025 Reset sequence: RST_N=0 for 4 units, KEY=0 -> STATE=0, LED=0 throughout.
REQ-026 Three 1-cycle KEY pulses 12 units apart -> STATE goes 1 (LED=1), then 2, then 0 (LED=0).
REQ-027 In BLINK, hold for 16 cycles -> LED is 1 for 4 cycles, 0 for 4 cycles, repeating.
REQ-028 RST_N=0 for 2 units during ON or BLINK, then one KEY pulse -> STATE=0 and LED=0 immediately, then STATE=1 and LED=1 after the press.
REQ-029 KEY held at 1 for 10 cycles from OFF -> exactly one advance, to STATE=1.
REQ-030 With LED_EX_KEY_SYNC_EN defined, one KEY pulse from OFF -> STATE=1 exactly 2 cycles later than in the undefined build.
